// File: rtl/pkt_size_meter_if.sv
// Beat stream into the size meter plus the (flow, size) update bus it emits.
interface pkt_size_meter_if #(
  parameter int A_WIDTH = 10,
  parameter int EMPTY_W = 2
);
  logic               s_valid_i;
  logic               s_ready_o;
  logic               s_sop_i;
  logic               s_eop_i;
  logic [EMPTY_W-1:0] s_empty_i;
  logic [A_WIDTH-1:0] s_flow_i;
  logic [A_WIDTH-1:0] rx_flow_num_o;
  logic [15:0]        pkt_size_o;
  logic               pkt_size_en_o;

  modport slave (
    input  s_valid_i, s_sop_i, s_eop_i, s_empty_i, s_flow_i,
    output s_ready_o, rx_flow_num_o, pkt_size_o, pkt_size_en_o
  );
  modport master (
    output s_valid_i, s_sop_i, s_eop_i, s_empty_i, s_flow_i,
    input  s_ready_o, rx_flow_num_o, pkt_size_o, pkt_size_en_o
  );
endinterface

// File: rtl/pkt_size_meter.sv
// Measures per-packet byte length from a sop/eop/empty beat stream and queues
// (flow, size) updates in a small FIFO that drains only while hold_i is low.
module pkt_size_meter #(
  parameter int A_WIDTH    = 10,
  parameter int BEAT_BYTES = 4,
  parameter int EMPTY_W    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pkt_size_meter_if.slave     s,
  input  logic                hold_i,
  output logic                err_o,
  output logic [15:0]         err_cnt_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = A_WIDTH + 16;

  typedef enum logic {IDLE, IN_PKT} state_e;

  state_e             state_q, state_d;
  logic [16:0]        cnt_q, cnt_d;
  logic [A_WIDTH-1:0] flow_q, flow_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic               rdy_q;
  logic [A_WIDTH-1:0] oflow_q;
  logic [15:0]        osize_q;
  logic               oen_q;
  logic               err_q;
  logic [15:0]        err_cnt_q, err_cnt_d;

  logic        accept, push, pop, err;
  logic [16:0] beat_bytes, sum;

  assign accept     = s.s_valid_i && rdy_q;
  assign beat_bytes = s.s_eop_i ? 17'(BEAT_BYTES) - 17'(s.s_empty_i) : 17'(BEAT_BYTES);
  assign sum        = cnt_q + beat_bytes;
  assign pop        = (fcnt_q != '0) && !hold_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flow_d  = flow_q;
    push    = 1'b0;
    err     = 1'b0;
    if (accept) begin
      if (s.s_sop_i) begin
        // A sop while a packet is open drops the old packet and restarts.
        err     = (state_q == IN_PKT);
        flow_d  = s.s_flow_i;
        cnt_d   = beat_bytes;
        push    = s.s_eop_i;
        state_d = s.s_eop_i ? IDLE : IN_PKT;
      end else if (state_q == IDLE) begin
        err = 1'b1;
      end else begin
        cnt_d   = (sum > 17'hFFFF) ? 17'hFFFF : sum;
        push    = s.s_eop_i;
        state_d = s.s_eop_i ? IDLE : IN_PKT;
      end
    end
  end

  always_comb begin
    fcnt_d = fcnt_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + CNT_W'(1);
      2'b01:   fcnt_d = fcnt_q - CNT_W'(1);
      default: fcnt_d = fcnt_q;
    endcase
    err_cnt_d = (err && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flow_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fcnt_q    <= '0;
      rdy_q     <= 1'b0;
      oflow_q   <= '0;
      osize_q   <= '0;
      oen_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flow_q    <= flow_d;
      fcnt_q    <= fcnt_d;
      rdy_q     <= (fcnt_d != CNT_W'(FIFO_DEPTH));
      oen_q     <= pop;
      err_q     <= err;
      err_cnt_q <= err_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        {oflow_q, osize_q} <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {flow_d, cnt_d[15:0]};
  end

  assign s.s_ready_o     = rdy_q;
  assign s.rx_flow_num_o = oflow_q;
  assign s.pkt_size_o    = osize_q;
  assign s.pkt_size_en_o = oen_q;
  assign err_o           = err_q;
  assign err_cnt_o       = err_cnt_q;
endmodule

// File: tb/tb_pkt_size_meter.sv
// Directed bench for pkt_size_meter: hand-computed sizes, flows, stalls and errors.
module tb_pkt_size_meter;
  localparam int A_WIDTH = 10;
  localparam int EMPTY_W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        err_o;
  logic [15:0] err_cnt_o;

  pkt_size_meter_if #(.A_WIDTH(A_WIDTH), .EMPTY_W(EMPTY_W)) bus ();

  pkt_size_meter #(.A_WIDTH(A_WIDTH), .BEAT_BYTES(4), .EMPTY_W(EMPTY_W), .FIFO_DEPTH(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s         (bus.slave),
    .hold_i    (hold),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { int flow; int size; int cyc; } upd_t;
  upd_t q[$];
  int   cyc = 0;
  int   err_seen = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.pkt_size_en_o === 1'b1)
      q.push_back('{int'(bus.rx_flow_num_o), int'(bus.pkt_size_o), cyc});
    if (err_o === 1'b1) err_seen++;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input bit sop, input bit eop, input int emp, input int flow);
    bit acc = 1'b0;
    bus.s_valid_i = 1'b1;
    bus.s_sop_i   = sop;
    bus.s_eop_i   = eop;
    bus.s_empty_i = EMPTY_W'(emp);
    bus.s_flow_i  = A_WIDTH'(flow);
    for (int n = 0; n < 200 && !acc; n++) begin
      if (bus.s_ready_o === 1'b1) acc = 1'b1;
      @(negedge clk);
    end
    bus.s_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_sop_i   = 1'b0;
    bus.s_eop_i   = 1'b0;
    bus.s_empty_i = '0;
    bus.s_flow_i  = '0;
    #1;
    chk("rst_ready", bus.s_ready_o, 0);
    chk("rst_en", bus.pkt_size_en_o, 0);
    chk("rst_errcnt", err_cnt_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", bus.s_ready_o, 1);

    // 1: single-beat sop+eop, flow 5, empty 1 -> size 3 after edge k+1
    send(1, 1, 1, 5);
    chk("t1_no_early_en", bus.pkt_size_en_o, 0);
    @(negedge clk);
    chk("t1_en", bus.pkt_size_en_o, 1);
    chk("t1_flow", bus.rx_flow_num_o, 5);
    chk("t1_size", bus.pkt_size_o, 3);
    @(negedge clk);
    chk("t1_en_one_cycle", bus.pkt_size_en_o, 0);
    chk("t1_no_err", err_seen, 0);
    q.delete();

    // 2: three beats, last empty 2 -> 4+4+2
    send(1, 0, 0, 2);
    send(0, 0, 0, 2);
    chk("t2_no_mid_out", q.size(), 0);
    send(0, 1, 2, 2);
    repeat (4) @(negedge clk);
    chk("t2_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t2_flow", q[0].flow, 2);
      chk("t2_size", q[0].size, 10);
    end
    q.delete();

    // 3: hold high, FIFO fills at 4 and stalls the stream
    hold = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 1, i % 4, 10 + i);
    chk("t3_ready_full", bus.s_ready_o, 0);
    bus.s_valid_i = 1'b1;
    bus.s_sop_i   = 1'b1;
    bus.s_eop_i   = 1'b1;
    bus.s_empty_i = EMPTY_W'(0);
    bus.s_flow_i  = A_WIDTH'(14);
    repeat (16) @(negedge clk);
    chk("t3_no_pulse_hold", q.size(), 0);
    chk("t3_still_stalled", bus.s_ready_o, 0);
    hold = 1'b0;
    send(1, 1, 0, 14);
    send(1, 1, 1, 15);
    repeat (10) @(negedge clk);
    chk("t3_count", q.size(), 6);
    if (q.size() == 6) begin
      chk("t3_f0", q[0].flow, 10); chk("t3_s0", q[0].size, 4);
      chk("t3_f1", q[1].flow, 11); chk("t3_s1", q[1].size, 3);
      chk("t3_f2", q[2].flow, 12); chk("t3_s2", q[2].size, 2);
      chk("t3_f3", q[3].flow, 13); chk("t3_s3", q[3].size, 1);
      chk("t3_f4", q[4].flow, 14); chk("t3_s4", q[4].size, 4);
      chk("t3_f5", q[5].flow, 15); chk("t3_s5", q[5].size, 3);
      chk("t3_b2b_1", q[1].cyc - q[0].cyc, 1);
      chk("t3_b2b_2", q[2].cyc - q[1].cyc, 1);
      chk("t3_b2b_3", q[3].cyc - q[2].cyc, 1);
    end
    q.delete();

    // 4: missing eop then sop+eop restart, then lone beat in IDLE
    send(1, 0, 0, 1);
    send(1, 1, 0, 7);
    send(0, 0, 0, 3);
    repeat (4) @(negedge clk);
    chk("t4_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t4_flow", q[0].flow, 7);
      chk("t4_size", q[0].size, 4);
    end
    chk("t4_err_pulses", err_seen, 2);
    chk("t4_err_cnt", err_cnt_o, 2);
    q.delete();

    // 5: 16400 beats = 65600 bytes -> saturated size
    send(1, 0, 0, 9);
    for (int i = 0; i < 16398; i++) send(0, 0, 0, 9);
    send(0, 1, 0, 9);
    repeat (4) @(negedge clk);
    chk("t5_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t5_flow", q[0].flow, 9);
      chk("t5_size", q[0].size, 16'hFFFF);
    end
    q.delete();

    // 6: reset mid-packet with two updates held
    hold = 1'b1;
    send(1, 1, 0, 20);
    send(1, 1, 1, 21);
    send(1, 0, 0, 4);
    chk("t6_held", q.size(), 0);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_rst_ready", bus.s_ready_o, 0);
    chk("t6_rst_en", bus.pkt_size_en_o, 0);
    chk("t6_rst_flow", bus.rx_flow_num_o, 0);
    chk("t6_rst_size", bus.pkt_size_o, 0);
    chk("t6_rst_err", err_o, 0);
    chk("t6_rst_errcnt", err_cnt_o, 0);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_stale", q.size(), 0);
    send(1, 1, 0, 6);
    repeat (4) @(negedge clk);
    chk("t6_count", q.size(), 1);
    if (q.size() > 0) begin
      chk("t6_flow", q[0].flow, 6);
      chk("t6_size", q[0].size, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkt_size_meter.md
Name: pkt_size_meter

Overview:
Upstream feeder for the per-flow packet-size accumulator. It measures packet length in bytes from a beat-oriented receive stream (sop/eop/empty) and tags each packet with the flow number captured at sop. On eop it emits one (flow, size) update pulse. A small output FIFO defers updates while hold_i is high, so no update collides with a read-and-clear strobe.

Parameters:
A_WIDTH, 10, flow number width; must match the accumulator.
BEAT_BYTES, 4, bytes per stream beat; power of 2, >= 2.
EMPTY_W, 2, width of s_empty_i; equals log2(BEAT_BYTES).
FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  reset, asynchronous assert, active-low.
s_valid_i  in  1  stream beat valid.
s_ready_o  out  1  stream ready; a beat is accepted when s_valid_i && s_ready_o.
s_sop_i  in  1  first beat of a packet.
s_eop_i  in  1  last beat of a packet.
s_empty_i  in  EMPTY_W  unused bytes in an eop beat; ignored on non-eop beats.
s_flow_i  in  A_WIDTH  flow number; sampled only on accepted sop beats.
hold_i  in  1  defer output; wired to the accumulator's rd_stb_i.
rx_flow_num_o  out  A_WIDTH  flow of the emitted update.
pkt_size_o  out  16  packet size in bytes, saturated.
pkt_size_en_o  out  1  one-cycle update strobe.
err_o  out  1  one-cycle framing-error pulse.
err_cnt_o  out  16  framing-error count, saturating.

Behaviour:
- Reset (rst_i low, async): FSM to IDLE, FIFO emptied, byte counter cleared. All outputs are 0 during reset, including s_ready_o. Any packet in progress and any queued updates are discarded. After release, s_ready_o = 1.
- Beat byte count:
  - eop beat: BEAT_BYTES - s_empty_i (range 1..BEAT_BYTES).
  - any other beat: BEAT_BYTES.
- FSM has two states, IDLE and IN_PKT.
- IDLE, accepted sop beat:
  - latch flow; load counter with the beat byte count.
  - if eop is also set: push (flow, size) to the FIFO and stay in IDLE.
  - otherwise go to IN_PKT.
- IDLE, accepted beat without sop: discard the beat; err_o pulses; err_cnt_o increments.
- IN_PKT, accepted non-sop beat: add the beat byte count. If eop is set, push and go to IDLE.
- IN_PKT, accepted sop beat (missing eop):
  - abort the old packet with no push; err_o pulses; err_cnt_o increments.
  - restart with this beat, same rules as an IDLE sop (including sop+eop single-beat handling).
- No accepted beat: state and counter hold.
- Counter arithmetic: 17-bit internal; saturates at 16'hFFFF and stays there until the packet ends. Reported size = min(count, 65535).
- FIFO:
  - push occurs on the clock edge that accepts the eop beat.
  - s_ready_o = (fifo_count != FIFO_DEPTH), driven from registered count, so a full FIFO stalls the stream.
  - a push and a pop in the same cycle are both performed and the count is unchanged.
- Output:
  - pop when the FIFO is non-empty and hold_i is low.
  - the output register loads on the pop edge; pkt_size_en_o is high for exactly the following cycle. Otherwise pkt_size_en_o is 0, and rx_flow_num_o/pkt_size_o hold their last values.
  - latency: eop accepted at edge k, hold_i low -> pkt_size_en_o high in the cycle after edge k+1.
  - order is strict FIFO; at most one update per cycle.
- hold_i high: no pop; updates accumulate. The cycle after hold_i drops, queued updates drain back-to-back.
- err_cnt_o saturates at 16'hFFFF. err_o and a push can coincide (abort plus a sop+eop restart).

Test Plan:
1. Reset released; one beat with sop+eop, flow 5, empty 1 -> one pkt_size_en_o pulse after edge k+1 with flow 5, size 3; err_o stays 0.
2. Flow 2, three beats, last with eop and empty 2 -> single pulse, size 10, flow 2; no output on intermediate beats.
3. hold_i high for 20 cycles while 6 single-beat packets are offered -> 4 queued, s_ready_o = 0 after the 4th; no pulses. hold_i drops -> 4 consecutive pulses in order, then the remaining 2 packets are accepted and emitted.
4. sop flow 1, one beat, then sop+eop flow 7, empty 0; then a lone non-sop beat in IDLE -> flow 1 never emitted; flow 7 size 4 emitted; two err_o pulses; err_cnt_o = 2.
5. 16400-beat packet (65600 bytes), flow 9 -> pkt_size_o = 16'hFFFF.
6. rst_i asserted mid-packet with 2 updates queued under hold -> all outputs 0 immediately; after release with hold_i low, no pulse appears; a fresh packet of size 4 is measured correctly.
